// File: rtl/matrix_buffer_pkg.sv
// Shared types and helpers for the matrix frame-store read side.
// Holds the read-scheduler state encoding, default lane geometry and
// width helpers used to size the address and cycle counters.
package matrix_buffer_pkg;

  localparam int DATA_COUNT_DEFAULT         = 12;
  localparam int BLOCK_DATA_WIDTH_B_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SWAP       = 3'd1,
    ST_WAIT_VALID = 3'd2,
    ST_FETCH      = 3'd3,
    ST_WAIT_DATA  = 3'd4,
    ST_PRESENT    = 3'd5,
    ST_DONE       = 3'd6
  } sched_state_e;

  // Bits needed to index n entries; never less than 1.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the shared down-counter: must hold TIMEOUT_CYCLES-1 and
  // READ_LATENCY-1 (latency is at most 4, so 2 bits minimum).
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = addr_width(timeout_cycles);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/matrix_read_latency_cnt.sv
// Small loadable down-counter. The scheduler uses it to time the buffer
// read latency and, when the watchdog is built in, the WAIT_VALID timeout.
// The two uses never overlap in time, so a single instance serves both.
module matrix_read_latency_cnt #(
  parameter int W = 4
) (
  input  logic         clk_a,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/matrix_read_scheduler.sv
// Read-side sequencer for the double-buffered matrix frame store.
// On a frame request: swap buffers, wait for data-valid, then for every
// read address strobe the buffer, capture the lane bytes and hand them to
// the SPI lane serializers.
// Optional watchdog on WAIT_VALID: define MATRIX_SCHED_TIMEOUT_EN.
//
// Lane handshake: O_lane_valid rises with fresh O_lane_data; both stay
// stable until a cycle with O_lane_valid=1 and I_lane_ready=1 (the
// transfer); O_lane_valid drops on the following cycle. I_lane_ready is
// ignored whenever O_lane_valid is low.
module matrix_read_scheduler
  import matrix_buffer_pkg::*;
#(
  parameter int ADDRESS_NUMBER_B   = 2250,
  parameter int DATA_COUNT         = DATA_COUNT_DEFAULT,
  parameter int BLOCK_DATA_WIDTH_B = BLOCK_DATA_WIDTH_B_DEFAULT,
  parameter int READ_LATENCY       = 1,
  parameter int TIMEOUT_CYCLES     = 1024,
  localparam int AW = addr_width(ADDRESS_NUMBER_B),
  localparam int DW = DATA_COUNT * BLOCK_DATA_WIDTH_B
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_frame_start,
  input  logic          I_data_valid,
  input  logic [DW-1:0] I_data_flat,
  output logic          O_swap_trigger,
  output logic          O_clk_data_out,
  output logic [AW-1:0] O_read_address,
  output logic [DW-1:0] O_lane_data,
  output logic          O_lane_valid,
  input  logic          I_lane_ready,
  output logic          O_busy,
  output logic          O_frame_done,
  output logic          O_overrun,
  output logic          O_error,
  output sched_state_e  O_dbg_state
);

  localparam int            CW        = cnt_width(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDRESS_NUMBER_B - 1);

  sched_state_e  state, state_next;
  logic [AW-1:0] addr_cnt;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_load_value;
  logic          last_addr, handshake, timeout_hit;

  assign last_addr = (addr_cnt == LAST_ADDR);
  assign handshake = (state == ST_PRESENT) && I_lane_ready;

`ifdef MATRIX_SCHED_TIMEOUT_EN
  assign timeout_hit = (state == ST_WAIT_VALID) && !I_data_valid && cnt_zero;
`else
  assign timeout_hit = 1'b0;
`endif

  matrix_read_latency_cnt #(.W(CW)) u_cnt (
    .clk_a      (I_clk),
    .rst_n      (I_rst_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State register.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (I_frame_start) state_next = ST_SWAP;
      ST_SWAP:       state_next = ST_WAIT_VALID;
      ST_WAIT_VALID: begin
        if (I_data_valid)     state_next = ST_FETCH;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_FETCH:      state_next = ST_WAIT_DATA;
      ST_WAIT_DATA:  if (cnt_zero) state_next = ST_PRESENT;
      ST_PRESENT:    if (I_lane_ready) state_next = last_addr ? ST_DONE : ST_FETCH;
      ST_DONE:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs and counter control. FETCH loads READ_LATENCY-1
  // so WAIT_DATA lasts exactly READ_LATENCY cycles.
  always_comb begin
    O_swap_trigger = (state == ST_SWAP);
    O_clk_data_out = (state == ST_FETCH);
    O_busy         = (state != ST_IDLE);
    O_frame_done   = (state == ST_DONE);
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    case (state)
      ST_FETCH: begin
        cnt_load       = 1'b1;
        cnt_load_value = CW'(READ_LATENCY - 1);
      end
      ST_WAIT_DATA: cnt_dec = 1'b1;
`ifdef MATRIX_SCHED_TIMEOUT_EN
      ST_SWAP: begin
        cnt_load       = 1'b1;
        cnt_load_value = CW'(TIMEOUT_CYCLES - 1);
      end
      ST_WAIT_VALID: begin
        if (I_data_valid) cnt_load = 1'b1;
        else              cnt_dec  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Address counter, lane capture register and overrun flag.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      addr_cnt     <= '0;
      O_lane_data  <= '0;
      O_lane_valid <= 1'b0;
      O_overrun    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && I_frame_start) addr_cnt <= '0;
      else if (handshake && !last_addr)        addr_cnt <= addr_cnt + AW'(1);
      else if (state == ST_DONE)               addr_cnt <= '0;

      if ((state == ST_WAIT_DATA) && cnt_zero) begin
        O_lane_data  <= I_data_flat;
        O_lane_valid <= 1'b1;
      end else if (handshake) begin
        O_lane_valid <= 1'b0;
      end

      if (I_frame_start && (state != ST_IDLE)) O_overrun <= 1'b1;
    end
  end

`ifdef MATRIX_SCHED_TIMEOUT_EN
  // Sticky watchdog flag; only a reset clears it.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n)         O_error <= 1'b0;
    else if (timeout_hit) O_error <= 1'b1;
  end
`else
  assign O_error = 1'b0;
`endif

  assign O_read_address = addr_cnt;
  assign O_dbg_state    = state;

endmodule

// File: tb/tb_matrix_read_scheduler.sv
// Bench for matrix_read_scheduler: buffer model with configurable read
// latency, lane-ready driver, streaming scoreboard and per-frame checks.
module tb_matrix_read_scheduler;
  import matrix_buffer_pkg::*;

  localparam int AN = 4;
  localparam int DC = 12;
  localparam int BW = 8;
  localparam int RL = 2;
  localparam int TO = 16;
  localparam int W  = DC * BW;
  localparam int AW = addr_width(AN);
  localparam int STEP = 2 + RL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          frame_start = 1'b0;
  logic          data_valid  = 1'b0;
  logic          lane_ready  = 1'b0;
  logic [W-1:0]  data_flat;
  logic          swap_trigger, clk_data_out, lane_valid, busy, frame_done, overrun, error;
  logic [AW-1:0] read_address;
  logic [W-1:0]  lane_data;
  sched_state_e  dbg_state;

  matrix_read_scheduler #(
    .ADDRESS_NUMBER_B   (AN),
    .DATA_COUNT         (DC),
    .BLOCK_DATA_WIDTH_B (BW),
    .READ_LATENCY       (RL),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .I_clk          (clk),
    .I_rst_n        (rst_n),
    .I_frame_start  (frame_start),
    .I_data_valid   (data_valid),
    .I_data_flat    (data_flat),
    .O_swap_trigger (swap_trigger),
    .O_clk_data_out (clk_data_out),
    .O_read_address (read_address),
    .O_lane_data    (lane_data),
    .O_lane_valid   (lane_valid),
    .I_lane_ready   (lane_ready),
    .O_busy         (busy),
    .O_frame_done   (frame_done),
    .O_overrun      (overrun),
    .O_error        (error),
    .O_dbg_state    (dbg_state)
  );

  // ---------------- buffer model ----------------
  logic [7:0]    salt = 8'h00;
  logic [AW-1:0] pipe_addr [RL];
  logic          pipe_vld  [RL] = '{default: 1'b0};

  function automatic logic [W-1:0] word_for(input int a, input logic [7:0] s);
    logic [W-1:0] w;
    for (int i = 0; i < DC; i++) w[i*BW +: BW] = 8'(a * 16 + i) + s;
    return w;
  endfunction

  always @(posedge clk) begin
    pipe_addr[0] <= read_address;
    pipe_vld[0]  <= clk_data_out;
    for (int k = 1; k < RL; k++) begin
      pipe_addr[k] <= pipe_addr[k-1];
      pipe_vld[k]  <= pipe_vld[k-1];
    end
  end

  assign data_flat = pipe_vld[RL-1] ? word_for(int'(pipe_addr[RL-1]), salt) : {DC{8'hEE}};

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int exp_addr = 0;
  int swap_cnt = 0, done_cnt = 0, strobe_cnt = 0, hs_cnt = 0;
  int first_strobe_cyc = -1, last_strobe_cyc = -1;
  logic prev_valid = 1'b0, prev_hs = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counters();
    swap_cnt = 0; done_cnt = 0; strobe_cnt = 0; hs_cnt = 0;
    first_strobe_cyc = -1; last_strobe_cyc = -1;
  endtask

  // Streaming monitor: address sequence, hold-while-stalled, data order.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (swap_trigger) swap_cnt++;
      if (frame_done)   done_cnt++;
      if (clk_data_out) begin
        check("strobe_addr", W'(read_address), W'(exp_addr));
        check("strobe_while_valid", W'(lane_valid), '0);
        if (strobe_cnt == 0) first_strobe_cyc = cyc;
        last_strobe_cyc = cyc;
        strobe_cnt++;
        exp_addr++;
      end
      if (prev_valid && !prev_hs) begin
        check("hold_valid", W'(lane_valid), W'(1));
        check("hold_data", lane_data, prev_data);
      end
      if (lane_valid && lane_ready) begin
        if (exp_q.size() == 0) check("hs_unexpected", W'(1), '0);
        else                   check("lane_data", lane_data, exp_q.pop_front());
        hs_cnt++;
      end
      prev_valid = lane_valid;
      prev_hs    = lane_valid && lane_ready;
      prev_data  = lane_data;
    end
  end

  // ---------------- drivers ----------------
  bit rand_ready = 1'b0;
  int stall_addr = -1;
  int stall_left = 0;

  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && lane_valid && int'(read_address) == stall_addr) begin
      lane_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      lane_ready = 1'($urandom_range(0, 1));
    end else begin
      lane_ready = 1'b1;
    end
  end

  task automatic pulse_start(output int start_cyc);
    @(posedge clk); #1;
    frame_start = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done_cnt > 0) got = 1'b1;
    end
    check("done_seen", W'(got), W'(1));
  endtask

  task automatic wait_strobes(input int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (strobe_cnt >= n) got = 1'b1;
    end
    check("strobe_reached", W'(got), W'(1));
  endtask

  task automatic load_frame(input logic [7:0] s);
    salt = s;
    exp_q.delete();
    for (int a = 0; a < AN; a++) exp_q.push_back(word_for(a, s));
    exp_addr = 0;
  endtask

  // One whole frame; valid_delay < 0 means data-valid is already high,
  // otherwise it rises valid_delay cycles after the swap pulse.
  task automatic run_frame(input string tag, input int valid_delay, input int st_addr,
                           input int st_len, input bit rnd, input logic [7:0] s,
                           input int exp_first, input int exp_span, input bit exp_ovr);
    int start_cyc;
    clear_counters();
    load_frame(s);
    rand_ready = rnd;
    stall_addr = st_addr;
    stall_left = st_len;
    data_valid = (valid_delay < 0);
    pulse_start(start_cyc);
    if (valid_delay >= 0) begin
      repeat (valid_delay) @(posedge clk);
      #1 data_valid = 1'b1;
    end
    wait_done();
    @(negedge clk);
    check({tag, "_busy_after"},   W'(busy), '0);
    check({tag, "_first_strobe"}, W'(first_strobe_cyc - start_cyc), W'(exp_first));
    if (exp_span >= 0)
      check({tag, "_span"}, W'(last_strobe_cyc - first_strobe_cyc), W'(exp_span));
    check({tag, "_swaps"},   W'(swap_cnt),     W'(1));
    check({tag, "_strobes"}, W'(strobe_cnt),   W'(AN));
    check({tag, "_dones"},   W'(done_cnt),     W'(1));
    check({tag, "_hs"},      W'(hs_cnt),       W'(AN));
    check({tag, "_q_empty"}, W'(exp_q.size()), '0);
    check({tag, "_overrun"}, W'(overrun),      W'(exp_ovr));
    rand_ready = 1'b0;
    stall_addr = -1;
  endtask

  typedef struct {
    string      name;
    int         valid_delay;
    int         stall_addr;
    int         stall_len;
    logic [7:0] salt;
    int         exp_first;
    int         exp_span;
  } vec_t;

  vec_t vecs[4];

  initial begin : safety
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sc;
    int vd;
    vecs[0] = '{"basic",        -1, -1, 0, 8'h00,  3, (AN-1)*STEP};
    vecs[1] = '{"backpressure", -1,  2, 7, 8'h00,  3, (AN-1)*STEP + 7};
    vecs[2] = '{"late_valid",   20, -1, 0, 8'h11, 22, (AN-1)*STEP};
    vecs[3] = '{"valid_d1",      1, -1, 0, 8'hA5,  3, (AN-1)*STEP};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_lane_data", lane_data, '0);
    check("rst_ctrl", W'({swap_trigger, clk_data_out, read_address, lane_valid, busy,
                          frame_done, overrun, error}), '0);
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ctrl", W'({swap_trigger, clk_data_out, read_address, lane_valid, busy,
                           frame_done, overrun, error}), '0);

    // Table-driven frames
    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].name, vecs[v].valid_delay, vecs[v].stall_addr, vecs[v].stall_len,
                1'b0, vecs[v].salt, vecs[v].exp_first, vecs[v].exp_span, 1'b0);

    // Randomized frames: random ready pattern and data-valid timing
    for (int r = 0; r < 6; r++) begin
      vd = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 12));
      run_frame("rand", vd, -1, 0, 1'b1, 8'($urandom), (vd < 0) ? 3 : 2 + vd, -1, 1'b0);
    end

    // Overrun: second request at address 1 is ignored, flag is sticky
    clear_counters();
    load_frame(8'h3C);
    data_valid = 1'b1;
    pulse_start(sc);
    wait_strobes(2);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_done();
    @(negedge clk);
    check("ovr_flag",    W'(overrun),    W'(1));
    check("ovr_strobes", W'(strobe_cnt), W'(AN));
    check("ovr_swaps",   W'(swap_cnt),   W'(1));
    check("ovr_q_empty", W'(exp_q.size()), '0);
    run_frame("after_ovr", -1, -1, 0, 1'b0, 8'h55, 3, (AN-1)*STEP, 1'b1);

    // Reset mid-frame at address 2
    clear_counters();
    load_frame(8'h70);
    data_valid = 1'b1;
    pulse_start(sc);
    wait_strobes(3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_lane_data", lane_data, '0);
    check("midrst_ctrl", W'({swap_trigger, clk_data_out, read_address, lane_valid, busy,
                             frame_done, overrun, error}), '0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("midrst_no_done",    W'(done_cnt),   '0);
    check("midrst_no_strobes", W'(strobe_cnt), W'(3));
    run_frame("post_rst", -1, -1, 0, 1'b0, 8'h09, 3, (AN-1)*STEP, 1'b0);

`ifdef MATRIX_SCHED_TIMEOUT_EN
    // Watchdog: data-valid never arrives
    clear_counters();
    exp_q.delete();
    data_valid = 1'b0;
    pulse_start(sc);
    repeat (TO + 1) @(negedge clk);
    check("wd_error_before", W'(error), '0);
    check("wd_state_before", W'(dbg_state), W'(ST_WAIT_VALID));
    @(negedge clk);
    check("wd_error",   W'(error),      W'(1));
    check("wd_state",   W'(dbg_state),  W'(ST_IDLE));
    check("wd_strobes", W'(strobe_cnt), '0);
    check("wd_dones",   W'(done_cnt),   '0);
`else
    check("error_tied_low", W'(error), '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
